tcycle_scheduler: RTL and testbench
===================================

Name: tcycle_scheduler

Overview:
Parametrised time-slot scheduler that divides the fast system clock into a repeating frame of per-unit slots (CPU, PPU, MEM, ...) followed by an optional settle window. It generates per-channel T-cycle tick strobes and an M-cycle strobe, and owns the shared memory port. Each channel's request is issued only during its own slot, and read data is routed back only to the slot owner. It replaces ad-hoc counter/state decoding in fpgaboy top level.

Parameters:
NUM_CH, 3, number of slot channels (>=1); channel i owns slot i
SLOT_LEN, 8, clk_in cycles per channel slot (>=2)
SETTLE_LEN, 1, idle cycles at end of frame (>=0); FRAME_LEN = NUM_CH*SLOT_LEN + SETTLE_LEN
ADDR_W, 16, memory address width
DATA_W, 8, memory data width

Ports:
clk_in  input  1  system clock (100 MHz)
rst_in  input  1  synchronous active-high reset
en_in  input  1  advance frame position when high; hold everything when low
slot_out  output  $clog2(NUM_CH) (min 1)  index of active slot (held at last slot value during settle)
slot_onehot_out  output  NUM_CH  one-hot active slot; all zero during settle
settle_out  output  1  high during settle window
tick_out  output  NUM_CH  one-cycle pulse at first cycle of channel slot
mtick_out  output  1  one-cycle pulse at frame start of every 4th frame
frame_cnt_out  output  2  frame count mod 4
req_addr_in  input  NUM_CH*ADDR_W  per-channel request address, channel i at [i*ADDR_W +: ADDR_W]
req_valid_in  input  NUM_CH  per-channel request valid
mem_addr_out  output  ADDR_W  address to memory
mem_valid_out  output  1  address valid to memory
mem_data_in  input  DATA_W  memory read data
mem_data_valid_in  input  1  memory read data valid
rsp_data_out  output  DATA_W  mem_data_in broadcast to all channels
rsp_valid_out  output  NUM_CH  per-channel response valid
drop_out  output  1  pulse: response arrived with no owner

Behaviour:
- Registered pos counter, 0..FRAME_LEN-1. Increments only when en_in=1, and wraps FRAME_LEN-1 -> 0. frame_cnt increments on wrap, mod 4.
- Reset: pos=0, frame_cnt=0, mem_addr_out=0, mem_valid_out=0.
- Outputs while rst_in is high or in the cycle after reset: slot_out=0, slot_onehot_out=1, settle_out=0; tick/mtick/rsp_valid/drop are 0 while rst_in=1.
- Slot decode (combinational from pos):
  - Slot i covers pos in [i*SLOT_LEN, (i+1)*SLOT_LEN-1].
  - settle covers pos >= NUM_CH*SLOT_LEN.
  - With SETTLE_LEN=0, settle_out is never asserted.
- tick_out[i] = en_in && pos==i*SLOT_LEN. Holding en_in low at a slot start does not repeat the pulse; it fires once, in the cycle pos advances.
- mtick_out = en_in && pos==0 && frame_cnt==0.
- Memory request:
  - On cycle with tick_out[i]=1 and req_valid_in[i]=1, latch channel i address.
  - Next clock: mem_addr_out=address, mem_valid_out=1.
  - mem_valid_out stays high through the last cycle of slot i, then clears on the clock where pos leaves the slot.
  - If req_valid_in[i]=0 at tick, there is no request that slot.
  - Requests outside a channel's tick are ignored; there is no queueing.
  - en_in low freezes mem_valid_out/mem_addr_out.
- Response routing:
  - rsp_valid_out[i] = mem_data_valid_in && slot_onehot_out[i] && mem_valid_out (combinational).
  - drop_out = mem_data_valid_in && (settle_out || !mem_valid_out).
- Reset mid-slot aborts any request (mem_valid_out=0 next cycle) and restarts the frame at slot 0.
- No combinational path from req_* to mem_*_out.

Test Plan:
Defaults (FRAME_LEN=25), reset, en_in=1 constant -> tick_out[0] at cycles 0,25,50; tick_out[1] at 8; tick_out[2] at 16; settle_out only at cycle 24; mtick_out at 0,100; frame_cnt_out=1 at cycle 25.
en_in low cycles 10-14 -> pos frozen at 10, slot_out=1, no ticks; tick_out[2] occurs at cycle 21; settle_out at cycle 29.
req_valid_in=3'b010, channel1 addr 0x8010 -> mem_addr_out=0x8010, mem_valid_out=1 cycles 9-15, 0 at 16; channel0/2 requests not issued when their valid is low.
During the above, mem_data_valid_in=1 with data 0xB3 at cycle 12 -> rsp_valid_out=3'b010, rsp_data_out=0xB3, drop_out=0. Same pulse at cycle 24 -> rsp_valid_out=0, drop_out=1.
rst_in for 1 cycle at cycle 13 during channel1 request -> cycle 14: mem_valid_out=0, slot_out=0, frame_cnt_out=0; tick_out[0] at first en_in cycle after reset.
NUM_CH=4, SLOT_LEN=4, SETTLE_LEN=0 -> frame length 16; tick_out[3] at cycle 12; settle_out never high; mtick_out at 0,64.

Source files
------------

// File: rtl/tcycle_scheduler.sv
// Frame/slot scheduler: per-unit T-cycle slots, M-cycle strobe,
// and ownership of the shared memory port by the active slot.
module tcycle_scheduler #(
   parameter int NUM_CH     = 3,
   parameter int SLOT_LEN   = 8,
   parameter int SETTLE_LEN = 1,
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 8,
   localparam int FRAME_LEN = NUM_CH*SLOT_LEN + SETTLE_LEN,
   localparam int ACT_LEN   = NUM_CH*SLOT_LEN,
   localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int PW = $clog2(FRAME_LEN)
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     en_in,
   output logic [SW-1:0]            slot_out,
   output logic [NUM_CH-1:0]        slot_onehot_out,
   output logic                     settle_out,
   output logic [NUM_CH-1:0]        tick_out,
   output logic                     mtick_out,
   output logic [1:0]               frame_cnt_out,
   input  logic [NUM_CH*ADDR_W-1:0] req_addr_in,
   input  logic [NUM_CH-1:0]        req_valid_in,
   output logic [ADDR_W-1:0]        mem_addr_out,
   output logic                     mem_valid_out,
   input  logic [DATA_W-1:0]        mem_data_in,
   input  logic                     mem_data_valid_in,
   output logic [DATA_W-1:0]        rsp_data_out,
   output logic [NUM_CH-1:0]        rsp_valid_out,
   output logic                     drop_out
);

   logic [PW-1:0]     pos;
   logic [PW:0]       posx;
   logic [1:0]        frame_cnt;
   logic              wrap;
   logic [SW-1:0]     slot_w;
   logic [NUM_CH-1:0] onehot_w;
   logic              settle_w;
   logic [NUM_CH-1:0] first_w;
   logic              last_w;
   logic              req_hit;
   logic [ADDR_W-1:0] req_sel;

   assign posx = {1'b0, pos};
   assign wrap = (pos == PW'(FRAME_LEN-1));

   // Frame position and frame counter advance only when enabled
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         pos       <= '0;
         frame_cnt <= '0;
      end else if (en_in) begin
         if (wrap) begin
            pos       <= '0;
            frame_cnt <= frame_cnt + 2'd1;
         end else begin
            pos <= pos + PW'(1);
         end
      end
   end

   // Decode slot owner, slot boundaries and settle window from pos
   always_comb begin
      slot_w   = SW'(NUM_CH-1);
      onehot_w = '0;
      first_w  = '0;
      last_w   = 1'b0;
      settle_w = !(posx < (PW+1)'(ACT_LEN));
      for (int i = NUM_CH-1; i >= 0; i--) begin
         if (posx < (PW+1)'((i+1)*SLOT_LEN))
            slot_w = SW'(i);
      end
      for (int i = 0; i < NUM_CH; i++) begin
         onehot_w[i] = !settle_w && (slot_w == SW'(i));
         first_w[i]  = (posx == (PW+1)'(i*SLOT_LEN));
         if (posx == (PW+1)'((i+1)*SLOT_LEN-1))
            last_w = 1'b1;
      end
   end

   // Strobes and slot outputs, forced to the slot-0 view in reset
   always_comb begin
      slot_out        = rst_in ? '0 : slot_w;
      slot_onehot_out = rst_in ? NUM_CH'(1) : onehot_w;
      settle_out      = !rst_in && settle_w;
      tick_out        = (rst_in || !en_in) ? '0 : first_w;
      mtick_out       = !rst_in && en_in && first_w[0]
                        && (frame_cnt == 2'd0);
      frame_cnt_out   = frame_cnt;
   end

   // Pick the request of the channel whose slot starts now
   always_comb begin
      req_hit = 1'b0;
      req_sel = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (tick_out[i] && req_valid_in[i]) begin
            req_hit = 1'b1;
            req_sel = req_addr_in[i*ADDR_W +: ADDR_W];
         end
      end
   end

   // Memory port: issue at slot start, hold to slot end
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         mem_addr_out  <= '0;
         mem_valid_out <= 1'b0;
      end else if (en_in) begin
         if (req_hit) begin
            mem_addr_out  <= req_sel;
            mem_valid_out <= 1'b1;
         end else if (last_w) begin
            mem_valid_out <= 1'b0;
         end
      end
   end

   // Route read data to the slot owner, flag orphaned responses
   always_comb begin
      rsp_data_out  = mem_data_in;
      rsp_valid_out = '0;
      drop_out      = 1'b0;
      if (!rst_in && mem_data_valid_in) begin
         if (mem_valid_out)
            rsp_valid_out = onehot_w;
         drop_out = settle_w || !mem_valid_out;
      end
   end

endmodule

// File: tb/tb_tcycle_scheduler.sv
// Directed bench for tcycle_scheduler: event scoreboard for strobes
// plus level checks on the memory port and routing.
module tb_tcycle_scheduler;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        en_in = 1'b0;
   logic [47:0] req_addr = {16'h2222, 16'h8010, 16'h1111};
   logic [2:0]  req_valid = '0;
   logic [7:0]  mem_data = 8'h00;
   logic        mem_dv = 1'b0;

   logic [1:0]  slot_a;
   logic [2:0]  oh_a;
   logic        settle_a;
   logic [2:0]  tick_a;
   logic        mtick_a;
   logic [1:0]  fc_a;
   logic [15:0] maddr_a;
   logic        mval_a;
   logic [7:0]  rdata_a;
   logic [2:0]  rval_a;
   logic        drop_a;

   logic [1:0]  slot_b;
   logic [3:0]  oh_b;
   logic        settle_b;
   logic [3:0]  tick_b;
   logic        mtick_b;
   logic [1:0]  fc_b;
   logic [15:0] maddr_b;
   logic        mval_b;
   logic [7:0]  rdata_b;
   logic [3:0]  rval_b;
   logic        drop_b;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = -1;
   bit mon_b   = 1'b0;
   int evq [11][$];
   string kname [11] = '{"tick0", "tick1", "tick2", "mtick",
      "settle", "rsp", "drop", "b_tick3", "b_mtick",
      "b_settle", "b_tick0"};

   always #5 clk_in = ~clk_in;

   tcycle_scheduler dut_a (
      .clk_in(clk_in), .rst_in(rst_in), .en_in(en_in),
      .slot_out(slot_a), .slot_onehot_out(oh_a),
      .settle_out(settle_a), .tick_out(tick_a),
      .mtick_out(mtick_a), .frame_cnt_out(fc_a),
      .req_addr_in(req_addr), .req_valid_in(req_valid),
      .mem_addr_out(maddr_a), .mem_valid_out(mval_a),
      .mem_data_in(mem_data), .mem_data_valid_in(mem_dv),
      .rsp_data_out(rdata_a), .rsp_valid_out(rval_a),
      .drop_out(drop_a)
   );

   tcycle_scheduler #(
      .NUM_CH(4), .SLOT_LEN(4), .SETTLE_LEN(0)
   ) dut_b (
      .clk_in(clk_in), .rst_in(rst_in), .en_in(en_in),
      .slot_out(slot_b), .slot_onehot_out(oh_b),
      .settle_out(settle_b), .tick_out(tick_b),
      .mtick_out(mtick_b), .frame_cnt_out(fc_b),
      .req_addr_in(64'h0), .req_valid_in(4'h0),
      .mem_addr_out(maddr_b), .mem_valid_out(mval_b),
      .mem_data_in(8'h00), .mem_data_valid_in(1'b0),
      .rsp_data_out(rdata_b), .rsp_valid_out(rval_b),
      .drop_out(drop_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
                tag, cyc, obs, exp);
      end
   endtask

   task automatic mon(input int k, input logic act);
      int e;
      if (act) begin
         if (evq[k].size() == 0) begin
            chk({kname[k], "_unexpected_q"},
                32'(evq[k].size()), 32'd1);
         end else begin
            e = evq[k].pop_front();
            chk({kname[k], "_cycle"}, 32'(cyc), 32'(e));
         end
      end
   endtask

   task automatic adv();
      @(posedge clk_in);
      #1;
   endtask

   task automatic sample();
      #1;
      mon(0, tick_a[0]);
      mon(1, tick_a[1]);
      mon(2, tick_a[2]);
      mon(3, mtick_a);
      mon(4, settle_a);
      mon(5, |rval_a);
      mon(6, drop_a);
      if (mon_b) begin
         mon(7, tick_b[3]);
         mon(8, mtick_b);
         mon(9, settle_b);
         mon(10, tick_b[0]);
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 11; k++)
         chk({kname[k], "_missing"}, 32'(evq[k].size()), 32'd0);
   endtask

   task automatic do_reset();
      adv();
      cyc = -1;
      rst_in = 1'b1;
      en_in = 1'b1;
      req_valid = 3'b111;
      mem_dv = 1'b1;
      mem_data = 8'h5A;
      sample();
      chk("rst_slot", 32'(slot_a), 32'd0);
      chk("rst_onehot", 32'(oh_a), 32'd1);
      chk("rst_settle", 32'(settle_a), 32'd0);
      chk("rst_rval", 32'(rval_a), 32'd0);
      adv();
      mem_dv = 1'b0;
      req_valid = 3'b000;
      sample();
      chk("rst_mval", 32'(mval_a), 32'd0);
      chk("rst_maddr", 32'(maddr_a), 32'd0);
      chk("rst_fc", 32'(fc_a), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      // free-running frames, both configurations
      do_reset();
      for (int f = 0; f <= 4; f++) evq[0].push_back(25*f);
      for (int f = 0; f <= 3; f++) begin
         evq[1].push_back(25*f + 8);
         evq[2].push_back(25*f + 16);
         evq[4].push_back(25*f + 24);
      end
      evq[3].push_back(0);
      evq[3].push_back(100);
      for (int k = 0; k <= 5; k++) evq[7].push_back(16*k + 12);
      for (int k = 0; k <= 6; k++) evq[10].push_back(16*k);
      evq[8].push_back(0);
      evq[8].push_back(64);
      mon_b = 1'b1;
      for (int c = 0; c <= 104; c++) begin
         adv();
         cyc = c;
         rst_in = 1'b0;
         en_in = 1'b1;
         sample();
         if (c % 25 == 0)
            chk("fc_frame", 32'(fc_a), 32'((c/25) % 4));
         if (c == 24) begin
            chk("fc24", 32'(fc_a), 32'd0);
            chk("slot_settle", 32'(slot_a), 32'd2);
            chk("oh_settle", 32'(oh_a), 32'd0);
         end
         if (c == 7) chk("slot7", 32'(slot_a), 32'd0);
         if (c == 8) chk("slot8", 32'(slot_a), 32'd1);
         if (c == 13) chk("b_slot13", 32'(slot_b), 32'd3);
      end
      mon_b = 1'b0;
      drain();

      // enable gaps mid-slot and at a slot start
      do_reset();
      evq[0].push_back(0);
      evq[0].push_back(33);
      evq[1].push_back(8);
      evq[2].push_back(21);
      evq[4].push_back(29);
      evq[3].push_back(0);
      for (int c = 0; c <= 34; c++) begin
         adv();
         cyc = c;
         rst_in = 1'b0;
         en_in = !((c >= 10 && c <= 14) || (c >= 30 && c <= 32));
         req_valid = 3'b010;
         sample();
         chk("gap_mval", 32'(mval_a), 32'(c >= 9 && c <= 20));
         if (c >= 10 && c <= 15) begin
            chk("gap_slot", 32'(slot_a), 32'd1);
            chk("gap_oh", 32'(oh_a), 32'd2);
         end
      end
      drain();

      // channel-1 request, response routing and drop
      do_reset();
      evq[0].push_back(0);
      evq[0].push_back(25);
      evq[1].push_back(8);
      evq[2].push_back(16);
      evq[4].push_back(24);
      evq[3].push_back(0);
      evq[5].push_back(12);
      evq[6].push_back(24);
      for (int c = 0; c <= 26; c++) begin
         adv();
         cyc = c;
         rst_in = 1'b0;
         en_in = 1'b1;
         req_valid = 3'b010;
         if (c >= 3 && c <= 6) req_valid[0] = 1'b1;
         if (c >= 18 && c <= 20) req_valid[2] = 1'b1;
         mem_dv = (c == 12 || c == 24);
         mem_data = mem_dv ? 8'hB3 : 8'h00;
         sample();
         chk("req_mval", 32'(mval_a), 32'(c >= 9 && c <= 15));
         if (c >= 9 && c <= 15)
            chk("req_maddr", 32'(maddr_a), 32'h8010);
         if (c == 12) begin
            chk("rsp_valid", 32'(rval_a), 32'd2);
            chk("rsp_data", 32'(rdata_a), 32'hB3);
            chk("rsp_nodrop", 32'(drop_a), 32'd0);
         end
         if (c == 24) chk("drop_rval", 32'(rval_a), 32'd0);
      end
      mem_dv = 1'b0;
      drain();

      // reset in the middle of a channel-1 request
      do_reset();
      evq[0].push_back(0);
      evq[0].push_back(14);
      evq[1].push_back(8);
      evq[3].push_back(0);
      evq[3].push_back(14);
      for (int c = 0; c <= 15; c++) begin
         adv();
         cyc = c;
         rst_in = (c == 13);
         en_in = 1'b1;
         req_valid = 3'b010;
         sample();
         if (c == 11) begin
            chk("mid_mval", 32'(mval_a), 32'd1);
            chk("mid_maddr", 32'(maddr_a), 32'h8010);
         end
         if (c == 13) chk("mid_rst_slot", 32'(slot_a), 32'd0);
         if (c == 14) begin
            chk("post_mval", 32'(mval_a), 32'd0);
            chk("post_slot", 32'(slot_a), 32'd0);
            chk("post_fc", 32'(fc_a), 32'd0);
         end
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
